vblank_update_scheduler: RTL and testbench

- Sequences game-state updates (ball physics, rod positions, score) so they touch the shared position register bank only while the display is in vertical blanking.
- Watches the display timing outputs Vactive and Hsync.
- Opens an update window at each start of blanking and grants the shared bank to one requester at a time, round-robin.
- Closes the window a fixed number of lines later, before active video resumes.

---
 rtl/vblank_update_scheduler_pkg.sv | 19 +
 rtl/vblank_update_scheduler_rr_arbiter.sv | 33 +++
 rtl/vblank_update_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_vblank_update_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vblank_update_scheduler_pkg.sv
// Shared types and constants for the vertical-blanking update scheduler.
// Imported by the top level (vblank_update_scheduler) and by rr_arbiter.
package vblank_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    CLOSE = 2'd3
  } sched_state_e;

  localparam int SYNC_STAGES = 2;

  localparam int REQ_BALL   = 0;
  localparam int REQ_ROD_P1 = 1;
  localparam int REQ_ROD_P2 = 2;
  localparam int REQ_SCORE  = 3;

endpackage

// File: rtl/vblank_update_scheduler_rr_arbiter.sv
// Combinational round-robin select: the first set request at or after the
// pointer, wrapping modulo NUM_REQ, returned one-hot with its index.
module rr_arbiter
  import vblank_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants the shared position register bank to one game-state updater at a time,
// only during vertical blanking. Optional macro: UPD_TIMEOUT_EN (per-grant watchdog).
module vblank_update_scheduler
  import vblank_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WINDOW_LINES   = 40,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               vactive_in,
  input  logic               hsync_in,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               window_open,
  output logic               frame_tick,
  output logic               abort,
  output logic [NUM_REQ-1:0] missed
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LINE_W = $clog2(WINDOW_LINES + 1);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(WINDOW_LINES);

  logic [SYNC_STAGES-1:0] r_vact_sync;
  logic [SYNC_STAGES-1:0] r_hs_sync;
  logic                   r_vact_d;
  logic                   r_hs_d;

  sched_state_e       r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_served;
  logic [NUM_REQ-1:0] r_missed;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gnt_idx;
  logic [LINE_W-1:0]  r_line_cnt;
  logic               r_window_open;
  logic               r_frame_tick;
  logic               r_abort;

  logic               w_vact_fall;
  logic               w_vact_rise;
  logic               w_hs_rise;
  logic               w_lines_done;
  logic               w_close;
  logic               w_release;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_pending;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [PTR_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic [PTR_W-1:0]   w_ptr_next;

  // Two-flop synchronizers followed by one edge-detect flop per timing input
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_vact_sync <= '0;
      r_hs_sync   <= '0;
      r_vact_d    <= 1'b0;
      r_hs_d      <= 1'b0;
    end else begin
      r_vact_sync <= {r_vact_sync[SYNC_STAGES-2:0], vactive_in};
      r_hs_sync   <= {r_hs_sync[SYNC_STAGES-2:0], hsync_in};
      r_vact_d    <= r_vact_sync[SYNC_STAGES-1];
      r_hs_d      <= r_hs_sync[SYNC_STAGES-1];
    end
  end

  assign w_vact_fall = r_vact_d & ~r_vact_sync[SYNC_STAGES-1];
  assign w_vact_rise = ~r_vact_d & r_vact_sync[SYNC_STAGES-1];
  assign w_hs_rise   = ~r_hs_d & r_hs_sync[SYNC_STAGES-1];

  // The line that completes the window closes it in the same cycle, so a
  // done arriving alongside that Hsync edge loses to the close.
  assign w_lines_done = r_window_open &&
                        ((r_line_cnt == LINE_MAX) ||
                         (w_hs_rise && (r_line_cnt == LINE_MAX - LINE_W'(1))));
  assign w_close      = w_lines_done || w_vact_rise;

  assign w_pending  = req & ~r_served;
  assign w_release  = (|(r_grant & done)) || !(|(r_grant & req));
  assign w_ptr_next = (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + PTR_W'(1);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req   (w_pending),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

`ifdef UPD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;

  // Expires on the last cycle of a TIMEOUT_CYCLES-long grant
  assign w_timeout = (r_state == GRANT) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
    end else if (r_state != GRANT) begin
      r_wd_cnt <= '0;
    end else if (!w_timeout) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end
`else
  // Watchdog compiled out: a grant is only released by done, req drop or close.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_served      <= '0;
      r_missed      <= '0;
      r_ptr         <= '0;
      r_gnt_idx     <= '0;
      r_line_cnt    <= '0;
      r_window_open <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      r_abort      <= 1'b0;

      if (r_window_open && w_hs_rise && (r_line_cnt != LINE_MAX)) begin
        r_line_cnt <= r_line_cnt + LINE_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_vact_fall) begin
            r_frame_tick  <= 1'b1;
            r_window_open <= 1'b1;
            r_line_cnt    <= '0;
            r_served      <= '0;
            r_missed      <= '0;
            r_state       <= ARB;
          end
        end

        ARB: begin
          if (w_close) begin
            r_state <= CLOSE;
          end else if (w_arb_valid) begin
            r_grant   <= w_arb_grant;
            r_gnt_idx <= w_arb_idx;
            r_state   <= GRANT;
          end
        end

        GRANT: begin
          if (w_close) begin
            r_state <= CLOSE;
          end else if (w_release || w_timeout) begin
            // A timed-out requester counts as served so it is not re-granted
            r_grant  <= '0;
            r_served <= r_served | r_grant;
            r_ptr    <= w_ptr_next;
            r_abort  <= !w_release;
            r_state  <= ARB;
          end
        end

        CLOSE: begin
          r_abort       <= |r_grant;
          r_missed      <= req & ~r_served & ~r_grant;
          r_grant       <= '0;
          r_window_open <= 1'b0;
          r_state       <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign window_open = r_window_open;
  assign frame_tick  = r_frame_tick;
  assign abort       = r_abort;
  assign missed      = r_missed;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed self-checking bench for vblank_update_scheduler (WINDOW_LINES=4,
// TIMEOUT_CYCLES=16); the timeout scenario follows UPD_TIMEOUT_EN.
module tb_vblank_update_scheduler;
  import vblank_sched_pkg::*;

  localparam logic [3:0] B_BALL   = 4'b0001 << REQ_BALL;
  localparam logic [3:0] B_ROD_P1 = 4'b0001 << REQ_ROD_P1;
  localparam logic [3:0] B_ROD_P2 = 4'b0001 << REQ_ROD_P2;
  localparam logic [3:0] B_SCORE  = 4'b0001 << REQ_SCORE;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic       vactive_in;
  logic       hsync_in;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       window_open;
  logic       frame_tick;
  logic       abort;
  logic [3:0] missed;

  int n_checks  = 0;
  int n_fail    = 0;
  int abort_cnt = 0;

  vblank_update_scheduler #(
    .NUM_REQ        (4),
    .WINDOW_LINES   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .vactive_in  (vactive_in),
    .hsync_in    (hsync_in),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .window_open (window_open),
    .frame_tick  (frame_tick),
    .abort       (abort),
    .missed      (missed)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (abort === 1'b1) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic serve(input logic [3:0] b);
    done = b;
    req  = req & ~b;
    step(1);
    done = 4'b0000;
  endtask

  task automatic open_win();
    vactive_in = 1'b0;
    step(3);
  endtask

  task automatic close_win();
    vactive_in = 1'b1;
    step(4);
  endtask

  task automatic hs_pulse();
    hsync_in = 1'b1;
    step(2);
    hsync_in = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b0; vactive_in = 1'b1; hsync_in = 1'b0; req = '0; done = '0;
    step(2);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL reset_window_open: got %b want 0", window_open); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL reset_missed: got %b want 0000", missed); end
    reset = 1'b1;
    step(4);
  endtask

  task automatic test_basic();
    req = B_BALL | B_ROD_P2;
    vactive_in = 1'b0;
    step(2);
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL basic_tick_early: got %b want 0", frame_tick); end
    step(1);
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL basic_tick: got %b want 1", frame_tick); end
    n_checks++; if (window_open !== 1'b1) begin n_fail++; $display("FAIL basic_open: got %b want 1", window_open); end
    step(1);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL basic_grant0: got %b want 0001", grant); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL basic_tick_pulse: got %b want 0", frame_tick); end
    step(9);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL basic_grant0_hold: got %b want 0001", grant); end
    serve(B_BALL);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL basic_release0: got %b want 0000", grant); end
    step(1);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL basic_grant2: got %b want 0100", grant); end
    step(9);
    serve(B_ROD_P2);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL basic_release2: got %b want 0000", grant); end
    close_win();
    n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL basic_closed: got %b want 0", window_open); end
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL basic_missed: got %b want 0000", missed); end
    n_checks++; if (abort_cnt !== 0) begin n_fail++; $display("FAIL basic_no_abort: got %0d want 0", abort_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [4];
    order[0] = B_ROD_P2; order[1] = B_SCORE; order[2] = B_BALL; order[3] = B_ROD_P1;
    // Pointer is 3 here; one frame serving requester 1 moves it to 2
    req = B_ROD_P1;
    open_win();
    step(1);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rr_wrap: got %b want 0010", grant); end
    serve(B_ROD_P1);
    close_win();
    req = 4'b1111;
    open_win();
    step(1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (grant !== order[i]) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", i, grant, order[i]); end
      serve(order[i]);
      step(1);
    end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_once: got %b want 0000", grant); end
    close_win();
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL rr_missed: got %b want 0000", missed); end
  endtask

  task automatic test_line_close();
    req = B_ROD_P1;
    open_win();
    step(1);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL lines_grant1: got %b want 0010", grant); end
    req = B_ROD_P1 | B_SCORE;
    repeat (3) hs_pulse();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL lines_hold3: got %b want 0010", grant); end
    n_checks++; if (window_open !== 1'b1) begin n_fail++; $display("FAIL lines_open3: got %b want 1", window_open); end
    hsync_in = 1'b1;
    step(2);
    hsync_in = 1'b0;
    step(1);
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL lines_abort_early: got %b want 0", abort); end
    step(1);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL lines_revoked: got %b want 0000", grant); end
    n_checks++; if (abort !== 1'b1) begin n_fail++; $display("FAIL lines_abort: got %b want 1", abort); end
    n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL lines_closed: got %b want 0", window_open); end
    n_checks++; if (missed !== 4'b1000) begin n_fail++; $display("FAIL lines_missed: got %b want 1000", missed); end
    step(1);
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL lines_abort_pulse: got %b want 0", abort); end
    req = '0;
    vactive_in = 1'b1;
    step(4);
    n_checks++; if (missed !== 4'b1000) begin n_fail++; $display("FAIL lines_missed_held: got %b want 1000", missed); end
    n_checks++; if (abort_cnt !== 1) begin n_fail++; $display("FAIL lines_abort_count: got %0d want 1", abort_cnt); end
  endtask

  task automatic test_done_vs_close();
    req = B_ROD_P1;
    open_win();
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL dvc_missed_cleared: got %b want 0000", missed); end
    step(1);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL dvc_grant1: got %b want 0010", grant); end
    repeat (3) hs_pulse();
    hsync_in = 1'b1;
    step(2);
    done = B_ROD_P1;
    step(1);
    done = '0;
    hsync_in = 1'b0;
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL dvc_close_wins: got %b want 0010", grant); end
    step(1);
    n_checks++; if (abort !== 1'b1) begin n_fail++; $display("FAIL dvc_abort: got %b want 1", abort); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL dvc_revoked: got %b want 0000", grant); end
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL dvc_missed: got %b want 0000", missed); end
    req = '0;
    step(1);
    vactive_in = 1'b1;
    step(4);
    n_checks++; if (abort_cnt !== 2) begin n_fail++; $display("FAIL dvc_abort_count: got %0d want 2", abort_cnt); end
  endtask

  task automatic test_timeout();
    req = B_BALL;
    open_win();
    step(1);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL to_grant0: got %b want 0001", grant); end
    req = B_BALL | B_ROD_P2;
`ifdef UPD_TIMEOUT_EN
    step(15);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL to_hold16: got %b want 0001", grant); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL to_abort_early: got %b want 0", abort); end
    step(1);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL to_revoked: got %b want 0000", grant); end
    n_checks++; if (abort !== 1'b1) begin n_fail++; $display("FAIL to_abort: got %b want 1", abort); end
    step(1);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL to_next: got %b want 0100", grant); end
    serve(B_ROD_P2);
    step(3);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL to_no_regrant: got %b want 0000", grant); end
    close_win();
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL to_missed: got %b want 0000", missed); end
    n_checks++; if (abort_cnt !== 3) begin n_fail++; $display("FAIL to_abort_count: got %0d want 3", abort_cnt); end
`else
    step(20);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL nowd_hold: got %b want 0001", grant); end
    n_checks++; if (abort_cnt !== 2) begin n_fail++; $display("FAIL nowd_abort_count: got %0d want 2", abort_cnt); end
    serve(B_BALL);
    step(1);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL nowd_next: got %b want 0100", grant); end
    serve(B_ROD_P2);
    close_win();
    n_checks++; if (missed !== 4'b0000) begin n_fail++; $display("FAIL nowd_missed: got %b want 0000", missed); end
`endif
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    int aborts_before;
    req = B_BALL;
    open_win();
    step(1);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 0001", grant); end
    step(2);
    aborts_before = abort_cnt;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_async_grant: got %b want 0000", grant); end
    n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL rst_async_open: got %b want 0", window_open); end
    step(2);
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL rst_no_abort: got %b want 0", abort); end
    reset = 1'b1;
    step(4);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_grant: got %b want 0000", grant); end
    n_checks++; if (window_open !== 1'b0) begin n_fail++; $display("FAIL rst_idle_open: got %b want 0", window_open); end
    n_checks++; if (abort_cnt !== aborts_before) begin n_fail++; $display("FAIL rst_abort_count: got %0d want %0d", abort_cnt, aborts_before); end
    vactive_in = 1'b1;
    step(4);
    open_win();
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL rst_reopen_tick: got %b want 1", frame_tick); end
    step(1);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b want 0001", grant); end
    serve(B_BALL);
    close_win();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_line_close();
    test_done_vs_close();
    test_timeout();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
